// File: rtl/au_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : au_reservation_station
//  Description : Four-entry reservation station feeding three arithmetic
//                units. Holds dispatched ops until both source operands are
//                valid, snoops the CDB for wakeup (including a same-cycle
//                dispatch bypass), and issues one ready entry per cycle
//                through registered issue outputs.
//                Optional macro RS_AGE_ORDER_EN: oldest-ready selection via
//                a 4x4 age matrix; otherwise the lowest-index ready entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module au_reservation_station (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [3:0]  disp_op,
    input  logic [4:0]  disp_rd_tag,
    input  logic        disp_rs1_valid,
    input  logic        disp_rs2_valid,
    input  logic [31:0] disp_rs1_data,
    input  logic [31:0] disp_rs2_data,
    input  logic [4:0]  disp_rs1_tag,
    input  logic [4:0]  disp_rs2_tag,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        flush,
    input  logic [2:0]  au_free,
    output logic        issue_valid,
    output logic [1:0]  issue_unit,
    output logic [3:0]  issue_op,
    output logic [4:0]  issue_rd_tag,
    output logic [31:0] issue_rs1_data,
    output logic [31:0] issue_rs2_data
);

    localparam int c_entries = 4;

    // Entry storage
    logic [c_entries-1:0] r_busy;
    logic [c_entries-1:0] r_s1_valid;
    logic [c_entries-1:0] r_s2_valid;
    logic [3:0]           r_op      [c_entries];
    logic [4:0]           r_rd_tag  [c_entries];
    logic [31:0]          r_s1_data [c_entries];
    logic [31:0]          r_s2_data [c_entries];
    logic [4:0]           r_s1_tag  [c_entries];
    logic [4:0]           r_s2_tag  [c_entries];

    logic [c_entries-1:0] w_free;
    logic [c_entries-1:0] w_alloc_oh;
    logic                 w_alloc;
    logic [c_entries-1:0] w_ready;
    logic [c_entries-1:0] w_sel_oh;
    logic [1:0]           w_sel_idx;
    logic                 w_issue;
    logic [1:0]           w_unit;
    logic [c_entries-1:0] w_wake1;
    logic [c_entries-1:0] w_wake2;
    logic                 w_byp1;
    logic                 w_byp2;

    assign w_free     = ~r_busy;
    // Freed-this-cycle entries are not visible here, so no same-cycle reuse.
    assign disp_ready = (|w_free) & ~flush;
    assign w_alloc    = disp_valid & disp_ready;
    // Isolate lowest set bit of the free mask to pick the allocation slot.
    assign w_alloc_oh = w_alloc ? (w_free & (~w_free + 4'd1)) : '0;
    assign w_ready    = r_busy & r_s1_valid & r_s2_valid;
    assign w_issue    = (|w_ready) & (|au_free);

    // A dispatched source waiting on the tag being broadcast right now.
    assign w_byp1 = cdb_valid & ~disp_rs1_valid & (disp_rs1_tag == cdb_tag);
    assign w_byp2 = cdb_valid & ~disp_rs2_valid & (disp_rs2_tag == cdb_tag);

    // Per-entry wakeup match against the CDB
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < c_entries; i++) begin
            w_wake1[i] = cdb_valid & r_busy[i] & ~r_s1_valid[i] & (r_s1_tag[i] == cdb_tag);
            w_wake2[i] = cdb_valid & r_busy[i] & ~r_s2_valid[i] & (r_s2_tag[i] == cdb_tag);
        end
    end

`ifdef RS_AGE_ORDER_EN
    // r_age[i][j] = 1 means entry i was allocated before entry j.
    logic [c_entries-1:0] r_age [c_entries];

    // New entry becomes younger than every other entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_entries; i++) begin
                r_age[i] <= '0;
            end
        end else if (w_alloc) begin
            for (int i = 0; i < c_entries; i++) begin
                if (w_alloc_oh[i]) begin
                    r_age[i] <= '0;
                end else begin
                    r_age[i] <= r_age[i] | w_alloc_oh;
                end
            end
        end
    end

    // Oldest ready entry: no other ready entry is older than it
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < c_entries; i++) begin
            w_sel_oh[i] = w_ready[i] &
                ~(|(w_ready & ~r_age[i] & ~(4'b0001 << i)));
        end
    end
`else
    // Lowest-index ready entry
    always_comb begin
        w_sel_oh = w_ready & (~w_ready + 4'd1);
    end
`endif

    // One-hot to index for the payload mux
    always_comb begin
        w_sel_idx = 2'd0;
        for (int i = 0; i < c_entries; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_idx = 2'(i);
            end
        end
    end

    // Target unit is the lowest idle AU
    always_comb begin
        w_unit = 2'd2;
        if (au_free[1]) w_unit = 2'd1;
        if (au_free[0]) w_unit = 2'd0;
    end

    // Entry state: allocation, wakeup and release on issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_s1_valid <= '0;
            r_s2_valid <= '0;
            for (int i = 0; i < c_entries; i++) begin
                r_op[i]      <= '0;
                r_rd_tag[i]  <= '0;
                r_s1_data[i] <= '0;
                r_s2_data[i] <= '0;
                r_s1_tag[i]  <= '0;
                r_s2_tag[i]  <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < c_entries; i++) begin
                if (w_alloc_oh[i]) begin
                    r_busy[i]     <= 1'b1;
                    r_op[i]       <= disp_op;
                    r_rd_tag[i]   <= disp_rd_tag;
                    r_s1_valid[i] <= disp_rs1_valid | w_byp1;
                    r_s2_valid[i] <= disp_rs2_valid | w_byp2;
                    r_s1_data[i]  <= w_byp1 ? cdb_data : disp_rs1_data;
                    r_s2_data[i]  <= w_byp2 ? cdb_data : disp_rs2_data;
                    r_s1_tag[i]   <= disp_rs1_tag;
                    r_s2_tag[i]   <= disp_rs2_tag;
                end else begin
                    if (w_issue && w_sel_oh[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                    if (w_wake1[i]) begin
                        r_s1_valid[i] <= 1'b1;
                        r_s1_data[i]  <= cdb_data;
                    end
                    if (w_wake2[i]) begin
                        r_s2_valid[i] <= 1'b1;
                        r_s2_data[i]  <= cdb_data;
                    end
                end
            end
        end
    end

    // Registered issue port; payload holds when nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid    <= 1'b0;
            issue_unit     <= '0;
            issue_op       <= '0;
            issue_rd_tag   <= '0;
            issue_rs1_data <= '0;
            issue_rs2_data <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (w_issue) begin
            issue_valid    <= 1'b1;
            issue_unit     <= w_unit;
            issue_op       <= r_op[w_sel_idx];
            issue_rd_tag   <= r_rd_tag[w_sel_idx];
            issue_rs1_data <= r_s1_data[w_sel_idx];
            issue_rs2_data <= r_s2_data[w_sel_idx];
        end else begin
            issue_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_au_reservation_station.sv
`timescale 1ns/1ps
module tb_au_reservation_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_op;
    logic [4:0]  disp_rd_tag;
    logic        disp_rs1_valid, disp_rs2_valid;
    logic [31:0] disp_rs1_data, disp_rs2_data;
    logic [4:0]  disp_rs1_tag, disp_rs2_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic [2:0]  au_free;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [3:0]  issue_op;
    logic [4:0]  issue_rd_tag;
    logic [31:0] issue_rs1_data, issue_rs2_data;

    au_reservation_station dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_rd_tag(disp_rd_tag),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs2_valid(disp_rs2_valid),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .au_free(au_free),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_op(issue_op), .issue_rd_tag(issue_rd_tag),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data)
    );

    always #5 clk = ~clk;

    // Reference model: a pool of slots, each remembering its dispatch order
    typedef struct {
        bit          busy;
        int unsigned seq;
        bit [3:0]    op;
        bit [4:0]    rd;
        bit          v1, v2;
        bit [31:0]   d1, d2;
        bit [4:0]    t1, t2;
    } ent_t;

    typedef struct {
        int        stamp;
        bit [1:0]  unit;
        bit [3:0]  op;
        bit [4:0]  rd;
        bit [31:0] d1, d2;
    } iss_t;

    ent_t        m [4];
    iss_t        expq [$];
    int unsigned seq_ctr = 0;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    bit [1:0]    last_unit = 0;
    bit [3:0]    last_op = 0;
    bit [4:0]    last_rd = 0;
    bit [31:0]   last_d1 = 0, last_d2 = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m[i].busy = 0;
        expq.delete();
        last_unit = 0; last_op = 0; last_rd = 0; last_d1 = 0; last_d2 = 0;
    endtask

    // Monitor: each issue expected in the cycle after it was selected
    initial begin
        iss_t e;
        forever begin
            @(negedge clk);
            while (expq.size() > 0 && expq[0].stamp < cyc - 1) begin
                e = expq.pop_front();
                chk("missed_issue", 32'd0, 32'd1);
            end
            if (expq.size() > 0 && expq[0].stamp == cyc - 1) begin
                e = expq.pop_front();
                chk("issue_valid", issue_valid, 1);
                chk("issue_unit", issue_unit, e.unit);
                chk("issue_op", issue_op, e.op);
                chk("issue_rd_tag", issue_rd_tag, e.rd);
                chk("issue_rs1_data", issue_rs1_data, e.d1);
                chk("issue_rs2_data", issue_rs2_data, e.d2);
                last_unit = e.unit; last_op = e.op; last_rd = e.rd;
                last_d1 = e.d1; last_d2 = e.d2;
            end else begin
                chk("issue_valid_idle", issue_valid, 0);
                chk("hold_op", issue_op, last_op);
                chk("hold_rd", issue_rd_tag, last_rd);
                chk("hold_unit", issue_unit, last_unit);
                chk("hold_rs1", issue_rs1_data, last_d1);
                chk("hold_rs2", issue_rs2_data, last_d2);
            end
        end
    end

    task automatic slot();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0; au_free = 3'b111;
    endtask

    task automatic disp(input bit [3:0] op, input bit [4:0] rd,
                        input bit v1, input bit [31:0] d1, input bit [4:0] t1,
                        input bit v2, input bit [31:0] d2, input bit [4:0] t2);
        disp_valid = 1; disp_op = op; disp_rd_tag = rd;
        disp_rs1_valid = v1; disp_rs1_data = d1; disp_rs1_tag = t1;
        disp_rs2_valid = v2; disp_rs2_data = d2; disp_rs2_tag = t2;
    endtask

    // Evaluate one cycle of the model against the inputs now applied
    task automatic eval();
        bit   exp_ready;
        int   sel;
        int   k;
        iss_t e;
        #1;
        exp_ready = 0;
        for (int i = 0; i < 4; i++) if (!m[i].busy) exp_ready = 1;
        if (flush) exp_ready = 0;
        chk("disp_ready", disp_ready, exp_ready);
        if (flush) begin
            for (int i = 0; i < 4; i++) m[i].busy = 0;
            return;
        end
        sel = -1;
        if (au_free != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i].busy && m[i].v1 && m[i].v2) begin
`ifdef RS_AGE_ORDER_EN
                    if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
        end
        if (sel >= 0) begin
            e.stamp = cyc;
            e.unit  = au_free[0] ? 2'd0 : (au_free[1] ? 2'd1 : 2'd2);
            e.op = m[sel].op; e.rd = m[sel].rd;
            e.d1 = m[sel].d1; e.d2 = m[sel].d2;
            expq.push_back(e);
        end
        if (cdb_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i].busy && !m[i].v1 && m[i].t1 == cdb_tag) begin m[i].v1 = 1; m[i].d1 = cdb_data; end
                if (m[i].busy && !m[i].v2 && m[i].t2 == cdb_tag) begin m[i].v2 = 1; m[i].d2 = cdb_data; end
            end
        end
        if (disp_valid && exp_ready) begin
            k = -1;
            for (int i = 3; i >= 0; i--) if (!m[i].busy) k = i;
            m[k].busy = 1; m[k].seq = seq_ctr++;
            m[k].op = disp_op; m[k].rd = disp_rd_tag;
            m[k].t1 = disp_rs1_tag; m[k].t2 = disp_rs2_tag;
            m[k].v1 = disp_rs1_valid; m[k].d1 = disp_rs1_data;
            m[k].v2 = disp_rs2_valid; m[k].d2 = disp_rs2_data;
            if (!disp_rs1_valid && cdb_valid && disp_rs1_tag == cdb_tag) begin m[k].v1 = 1; m[k].d1 = cdb_data; end
            if (!disp_rs2_valid && cdb_valid && disp_rs2_tag == cdb_tag) begin m[k].v2 = 1; m[k].d2 = cdb_data; end
        end
        if (sel >= 0) m[sel].busy = 0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin slot(); idle(); eval(); end
    endtask

    task automatic mid_reset();
        slot();
        rst_n = 0; idle();
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_op", issue_op, 0);
        chk("rst_issue_rs1", issue_rs1_data, 0);
        chk("rst_disp_ready", disp_ready, 1);
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; idle();
        disp_op = 0; disp_rd_tag = 0; disp_rs1_valid = 0; disp_rs2_valid = 0;
        disp_rs1_data = 0; disp_rs2_data = 0; disp_rs1_tag = 0; disp_rs2_tag = 0;
        cdb_tag = 0; cdb_data = 0;
        model_clear();
        #2;
        chk("reset_issue_valid", issue_valid, 0);
        chk("reset_issue_unit", issue_unit, 0);
        chk("reset_issue_rd", issue_rd_tag, 0);
        chk("reset_issue_rs2", issue_rs2_data, 0);
        @(posedge clk); #2; rst_n = 1;
        #1 chk("reset_disp_ready", disp_ready, 1);

        // Basic issue of a fully-ready op
        slot(); idle(); disp(1, 3, 1, 10, 0, 1, 10, 0); eval();
        run_idle(3);

        // Wakeup via CDB three cycles after dispatch
        slot(); idle(); disp(2, 5, 0, 0, 7, 1, 20, 0); eval();
        run_idle(2);
        slot(); idle(); cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h55; eval();
        run_idle(3);

        // Fill all entries, attempt a fifth, then free one
        for (int i = 0; i < 4; i++) begin
            slot(); idle(); disp(4'(i + 3), 5'(i + 10), 0, 0, 5'(20 + i), 1, 5, 0); eval();
        end
        slot(); idle(); disp(9, 9, 1, 1, 0, 1, 1, 0); eval();
        slot(); idle(); cdb_valid = 1; cdb_tag = 21; cdb_data = 32'hABC; eval();
        run_idle(3);
        slot(); idle(); flush = 1; eval();
        run_idle(1);

        // Dispatch bypass on rs2
        slot(); idle(); disp(6, 8, 1, 1, 0, 0, 0, 4); cdb_valid = 1; cdb_tag = 4; cdb_data = 99; eval();
        run_idle(3);

        // No free AU, then only AU 2 free
        slot(); idle(); au_free = 3'b000; disp(7, 12, 1, 3, 0, 1, 4, 0); eval();
        for (int i = 0; i < 2; i++) begin slot(); idle(); au_free = 3'b000; eval(); end
        slot(); idle(); au_free = 3'b100; eval();
        run_idle(2);

        // Ordering: entry 2 allocated before entry 0, both woken together
        slot(); idle(); au_free = 0; disp(1, 1, 1, 11, 0, 1, 11, 0); eval();
        slot(); idle(); au_free = 0; disp(2, 2, 0, 0, 10, 1, 22, 0); eval();
        slot(); idle(); au_free = 0; disp(3, 3, 0, 0, 9, 1, 33, 0); eval();
        slot(); idle(); au_free = 3'b001; eval();
        slot(); idle(); au_free = 0; disp(4, 4, 0, 0, 9, 1, 44, 0); eval();
        slot(); idle(); au_free = 0; cdb_valid = 1; cdb_tag = 9; cdb_data = 32'h909; eval();
        run_idle(1);
        slot(); idle(); flush = 1; eval();
        run_idle(2);

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) mid_reset();
            slot(); idle();
            if ($urandom_range(0, 1) == 1)
                disp(4'($urandom), 5'($urandom),
                     1'($urandom), $urandom, 5'($urandom_range(0, 7)),
                     1'($urandom), $urandom, 5'($urandom_range(0, 7)));
            cdb_valid = 1'($urandom);
            cdb_tag   = 5'($urandom_range(0, 7));
            cdb_data  = $urandom;
            au_free   = 3'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            eval();
        end

        // Drain: broadcast every tag so every entry can issue
        for (int t = 0; t < 8; t++) begin
            slot(); idle(); cdb_valid = 1; cdb_tag = 5'(t); cdb_data = 32'(t * 3 + 1); eval();
        end
        run_idle(6);
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
